regfile_alu_pipe: RTL
=====================

// Module: regfile_alu_pipe
// PURPOSE
//  Parametrised successor to the combined register file + ALU datapath. Adds an issue/execute
//  pipeline with operand forwarding, a Ready/Valid handshake and a multi-cycle iterative multiply.
//  Sits between the instruction decoder and the memory/writeback path of the CPU core.
// PARAMETERS
//  DATA_W  16  datapath, register and immediate width
//  NREGS   16  number of general registers
//  ADDR_W  $clog2(NREGS)  register address width (derived; do not override)
// PORTS
//  Clk          in   1       clock, all state updates on rising edge
//  Rst          in   1       asynchronous, active-low reset
//  En           in   1       issue request; accepted at a rising edge when En && Ready
//  Ready        out  1       1 = may issue this cycle; 0 while MUL executes
//  RdestRegLoc  in   ADDR_W  destination register / operand A
//  RsrcRegLoc   in   ADDR_W  source register / operand B when Imm_s=0
//  Imm          in   DATA_W  immediate operand B when Imm_s=1
//  Imm_s        in   1       1 = operand B is Imm
//  OpCode       in   5       operation (encodings in regfile_alu_pkg)
//  AluOutput    out  DATA_W  registered result of the last completed op
//  RdestOut     out  DATA_W  combinational read of reg[RdestRegLoc] (current contents)
//  Flags        out  5       {C,L,F,Z,N}; registered, updated on completion
//  Valid        out  1       one-cycle pulse: AluOutput/Flags just updated
// BEHAVIOUR
//  Reset (Rst=0, async): all regs=0, AluOutput=0, Flags=0, Valid=0, Ready=1, pipeline empty.
//  Reset mid-MUL aborts it: no write-back, no Valid.
//  Issue edge N: latch opcode, Rdest, A=reg[Rdest], B=Imm_s?Imm:reg[Rsrc] into E stage.
//  Single-cycle ops complete at edge N+1: write reg[Rdest], AluOutput, Flags; Valid=1 for that
//  cycle. Back-to-back issue every cycle allowed.
//  Forwarding: if E stage writes at the same edge as a new issue and its Rdest equals the issuing
//  Rdest/Rsrc, the new operand takes the E-stage result, not stale reg contents.
//  Ops: ADD=A+B, SUB=A-B, CMP (flags only, no write), AND, OR, XOR, MOV=B,
//  LSH = A<<B[3:0] if B signed >=0 else A>>|B| (logical), MUL = low DATA_W of A*B.
//  Undefined opcodes = NOP: no write, Flags held, Valid=1.
//  Flags:
//   - C = unsigned carry/borrow (ADD/SUB/CMP); for MUL, C = (high half != 0).
//   - F = signed overflow (ADD/SUB).
//   - L = A<B unsigned; N = A<B signed (CMP/SUB); other ops: L=N=0.
//   - Z = result==0 (for CMP: A==B). Logic/shift/MOV clear C and F.
//  MUL: issue at edge N -> Ready=0 from N; shift-add over DATA_W edges; result write, Valid and
//  Ready=1 at edge N+DATA_W. En is ignored while Ready=0 (no queueing).
//  Writes target Rdest only; reg 0 is an ordinary register. Rdest==Rsrc is legal.
//  RdestOut reflects write-back in the cycle after the write edge.
//  Arithmetic wraps modulo 2^DATA_W.
// STRUCTURE
//  regfile_alu_pkg: OpCode localparams, flag bit indices (FLG_C=4 .. FLG_N=0), MUL step count.
//  One sub-module: seq_mult (start/busy/done, DATA_W-cycle shift-add, 2*DATA_W product).
//  Register array, forwarding muxes and ALU stay in this module.
// TESTING
//  1. Reset pulse, Rdest=0 -> RdestOut=0, AluOutput=0, Flags=0, Ready=1, Valid=0.
//  2. ADD r0,#5 then ADD r0,#5 back-to-back -> AluOutput 5 then 10 (forwarded); RdestOut=10.
//  3. r1=0x7FFF, ADD r1,#1 -> 0x8000, F=1, N-flag per rules, C=0; 0xFFFF+1 -> 0, C=1, Z=1.
//  4. CMP r2(3),#5 -> L=1, N=1, Z=0, r2 still 3; CMP equal -> Z=1.
//  5. r3=300, MUL r3,#300 -> Ready low 16 cycles, En ignored, result 0x5F90, C=1, one Valid pulse.
//  6. Start MUL, assert Rst at cycle 5 -> no write, Ready=1, Valid never pulses, regs=0.

Source files
------------

// File: rtl/regfile_alu_pipe_pkg.sv
// Shared opcode encodings, flag layout and multiplier sizing for the register-file/ALU pipeline.
package regfile_alu_pipe_pkg;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_CMP = 5'd2,
        OP_AND = 5'd3,
        OP_OR  = 5'd4,
        OP_XOR = 5'd5,
        OP_MOV = 5'd6,
        OP_LSH = 5'd7,
        OP_MUL = 5'd8
    } opcode_e;

    localparam int FLG_C = 4;
    localparam int FLG_L = 3;
    localparam int FLG_F = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    typedef struct packed {
        logic c;
        logic l;
        logic f;
        logic z;
        logic n;
    } flags_t;

    // One shift-add step per multiplier bit.
    function automatic int mul_steps(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/regfile_alu_pipe_if.sv
// Issue/result bus between the decoder (master) and the register-file/ALU pipeline (slave).
interface regfile_alu_pipe_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              en;
    logic              ready;
    logic [ADDR_W-1:0] rdest_reg_loc;
    logic [ADDR_W-1:0] rsrc_reg_loc;
    logic [DATA_W-1:0] imm;
    logic              imm_s;
    logic [4:0]        op_code;
    logic [DATA_W-1:0] alu_output;
    logic [DATA_W-1:0] rdest_out;
    logic [4:0]        flags;
    logic              valid;

    modport master (
        output en, rdest_reg_loc, rsrc_reg_loc, imm, imm_s, op_code,
        input  ready, alu_output, rdest_out, flags, valid
    );

    modport slave (
        input  en, rdest_reg_loc, rsrc_reg_loc, imm, imm_s, op_code,
        output ready, alu_output, rdest_out, flags, valid
    );
endinterface

// File: rtl/regfile_alu_pipe_seq_mult.sv
// Iterative shift-add multiplier: one multiplier bit per clock, full 2*DATA_W product.
module seq_mult
    import regfile_alu_pipe_pkg::*;
#(
    parameter int DATA_W = 16
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);
    localparam int STEPS = mul_steps(DATA_W);
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [2*DATA_W-1:0] partial;
    logic [DATA_W-1:0]   mplier_q;

    // product is the accumulator after the current step, so the final value is usable on the done edge
    assign partial = mplier_q[0] ? mcand_q : '0;
    assign product = acc_q + partial;
    assign done    = busy && (cnt_q == CNT_W'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt_q <= '0;
        end else if (busy) begin
            busy  <= !done;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{DATA_W{1'b0}}, a};
            mplier_q <= b;
        end else if (busy) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/regfile_alu_pipe.sv
// Register file + ALU with a one-deep execute stage, result forwarding and an iterative MUL.
module regfile_alu_pipe
    import regfile_alu_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
)(
    input logic               clk,
    input logic               rst_n,
    regfile_alu_pipe_if.slave bus
);
    localparam int ADDR_W = $clog2(NREGS);
    localparam int MSB    = DATA_W - 1;

    logic [DATA_W-1:0]   regs [NREGS];
    logic                vld_p1;
    logic [4:0]          op_p1;
    logic [ADDR_W-1:0]   rdest_p1;
    logic [DATA_W-1:0]   a_p1;
    logic [DATA_W-1:0]   b_p1;
    logic [DATA_W-1:0]   alu_q;
    flags_t              flags_q;
    logic                valid_q;

    logic                mul_busy;
    logic                mul_done;
    logic                mul_start;
    logic [2*DATA_W-1:0] mul_prod;

    logic                issue;
    logic                complete;
    logic                wb_en;
    logic                writes;
    logic                defined;
    logic [DATA_W-1:0]   res;
    logic [DATA_W-1:0]   opa;
    logic [DATA_W-1:0]   opb;
    logic [DATA_W-1:0]   src_val;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     dif;
    flags_t              fl_nx;

    assign bus.ready  = !mul_busy;
    assign issue      = bus.en && !mul_busy;
    assign mul_start  = issue && (bus.op_code == OP_MUL);
    assign complete   = vld_p1 && ((op_p1 != OP_MUL) || mul_done);
    assign wb_en      = complete && writes;

    // Issue stage: a result retiring on this edge bypasses the register array
    assign opa     = (wb_en && rdest_p1 == bus.rdest_reg_loc) ? res : regs[bus.rdest_reg_loc];
    assign src_val = (wb_en && rdest_p1 == bus.rsrc_reg_loc)  ? res : regs[bus.rsrc_reg_loc];
    assign opb     = bus.imm_s ? bus.imm : src_val;

    assign bus.rdest_out  = regs[bus.rdest_reg_loc];
    assign bus.alu_output = alu_q;
    assign bus.flags      = flags_q;
    assign bus.valid      = valid_q;

    seq_mult #(.DATA_W(DATA_W)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (opa),
        .b       (opb),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Execute stage: combinational ALU on the latched operands
    always_comb begin
        sum     = {1'b0, a_p1} + {1'b0, b_p1};
        dif     = {1'b0, a_p1} - {1'b0, b_p1};
        b_mag   = -b_p1;
        res     = '0;
        fl_nx   = '0;
        writes  = 1'b1;
        defined = 1'b1;
        case (op_p1)
            OP_ADD: begin
                res     = sum[MSB:0];
                fl_nx.c = sum[DATA_W];
                fl_nx.f = (a_p1[MSB] == b_p1[MSB]) && (sum[MSB] != a_p1[MSB]);
            end
            OP_SUB, OP_CMP: begin
                res     = dif[MSB:0];
                fl_nx.c = dif[DATA_W];
                fl_nx.f = (op_p1 == OP_SUB) && (a_p1[MSB] != b_p1[MSB]) && (dif[MSB] != a_p1[MSB]);
                fl_nx.l = a_p1 < b_p1;
                fl_nx.n = $signed(a_p1) < $signed(b_p1);
                writes  = (op_p1 == OP_SUB);
            end
            OP_AND:  res = a_p1 & b_p1;
            OP_OR:   res = a_p1 | b_p1;
            OP_XOR:  res = a_p1 ^ b_p1;
            OP_MOV:  res = b_p1;
            OP_LSH:  res = b_p1[MSB] ? (a_p1 >> b_mag) : (a_p1 << b_p1[3:0]);
            OP_MUL: begin
                res     = mul_prod[MSB:0];
                fl_nx.c = |mul_prod[2*DATA_W-1:DATA_W];
            end
            default: begin
                writes  = 1'b0;
                defined = 1'b0;
            end
        endcase
        fl_nx.z = (res == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            op_p1    <= '0;
            rdest_p1 <= '0;
            valid_q  <= 1'b0;
            alu_q    <= '0;
            flags_q  <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            valid_q <= complete;
            if (issue) begin
                vld_p1   <= 1'b1;
                op_p1    <= bus.op_code;
                rdest_p1 <= bus.rdest_reg_loc;
            end else if (complete) begin
                vld_p1 <= 1'b0;
            end
            if (complete && defined) begin
                alu_q   <= res;
                flags_q <= fl_nx;
            end
            if (wb_en) regs[rdest_p1] <= res;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            a_p1 <= opa;
            b_p1 <= opb;
        end
    end

endmodule
